ctrl_seq_m: RTL and testbench
=============================

Name: ctrl_seq_m

Overview:
- 8-phase instruction sequencer for the 8-bit accumulator CPU; the control side of the ALU opcode/zero interface.
- Consumes the instruction-register opcode and the ALU `zero` flag.
- Produces memory, PC, IR and accumulator strobes, one instruction per 8 clocks.
- Sits between the instruction register and the datapath (ALU, accumulator, PC, memory).

Parameters:
HALT_STICKY, 1, 1: HLT freezes the sequencer until reset. 0: `halt` pulses for one phase and sequencing continues.

Ports:
clk      input   1  system clock, all state on posedge
rst      input   1  synchronous active-high reset
opcode   input   3  current IR opcode: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7
zero     input   1  ALU accumulator-is-zero flag
mem_rd   output  1  memory read enable
load_ir  output  1  instruction register load
inc_pc   output  1  program counter increment
load_pc  output  1  program counter load (jump)
load_ac  output  1  accumulator load from ALU out
mem_wr   output  1  memory write strobe
data_e   output  1  accumulator drives data bus
halt     output  1  processor halted
phase    output  3  current phase (debug)

Behaviour:
- Reset: one clock; reset is synchronous and active-high (ports `clk`, `rst`). While `rst`=1 at a posedge: `phase`<=0, halted flag<=0. After that edge all outputs are 0. Reset mid-instruction, including while halted, aborts and restarts at phase 0.
- Phase counter: 3-bit. Increments every clock and wraps 7->0. No stall input.
- Phases: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- Outputs are combinational decodes of registered `phase`, halted flag, `opcode` and `zero`.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Decode per phase (outputs not listed are 0):
  - 0: none.
  - 1: mem_rd.
  - 2: mem_rd, load_ir.
  - 3: mem_rd, load_ir.
  - 4: inc_pc; halt = (opcode==HLT).
  - 5: mem_rd = ALUOP.
  - 6: mem_rd = ALUOP; load_ac = ALUOP; inc_pc = (opcode==SKZ && zero); load_pc = (opcode==JMP); data_e = (opcode==STO).
  - 7: mem_rd = ALUOP; load_ac = ALUOP; inc_pc = (opcode==JMP); load_pc = (opcode==JMP); data_e = (opcode==STO); mem_wr = (opcode==STO).
- HALT_STICKY=1:
  - At the posedge ending phase 4 with opcode==HLT, the halted flag is set and `phase` holds at 4.
  - While halted: `halt`=1, every other strobe = 0, `phase` reads 4, `opcode`/`zero` changes are ignored.
  - Only `rst` clears the halted flag.
- HALT_STICKY=0: `halt` is high only during phase 4 of an HLT instruction, and the phase keeps wrapping.
- `zero` is sampled only in phase 6 for SKZ. `zero` is don't-care for all other opcodes and phases.
- `opcode` is don't-care in phases 0-3, because IR is being loaded.
- Output invariants:
  - mem_rd and mem_wr are never both 1.
  - load_pc implies opcode==JMP.
  - At most one of inc_pc/load_pc may be 1 in phase 6. Both are 1 in phase 7 for JMP: PC load has priority in the PC block.
- Outputs never X after the first reset edge, given known opcode/zero.

Test Plan:
- Reset/wrap: assert rst 2 clocks, release, opcode=ADD -> phase sequence 0,1,...,7,0; mem_rd=1 in phases 1,2,3,5,6,7; load_ir=1 in phases 2,3; inc_pc=1 in phase 4; load_ac=1 in phases 6,7; mem_wr=data_e=0 throughout.
- STO: opcode=STO for one instruction -> mem_rd=0 in phases 5-7; data_e=1 in phases 6,7; mem_wr=1 only in phase 7; load_ac=0.
- SKZ: opcode=SKZ, zero=1 -> inc_pc=1 in phases 4 and 6 (two increments). Repeat with zero=0 -> inc_pc=1 only in phase 4.
- JMP: opcode=JMP -> load_pc=1 in phases 6,7; inc_pc=1 in phases 4,7; mem_rd=0 in phases 5-7.
- HLT sticky (HALT_STICKY=1): opcode=HLT -> halt=1 from phase 4; phase stays 4 for 20 clocks with all strobes 0 while opcode toggles; rst for 1 clock -> phase=0, halt=0.
- Reset mid-op / non-sticky: rst asserted during phase 6 of ADD -> next cycle phase=0, load_ac=0. With HALT_STICKY=0 and opcode=HLT -> halt=1 only in phase 4; phase reaches 5 on the next clock.

Source files
------------

// File: rtl/ctrl_seq_m.sv
// 8-phase instruction sequencer for the 8-bit accumulator CPU.
// Decodes phase, halted flag, IR opcode and ALU zero into datapath strobes.
module ctrl_seq_m #(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       mem_rd,
    output logic       load_ir,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       load_ac,
    output logic       mem_wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned OP_W    = 3;

    localparam logic [OP_W-1:0] OP_HLT = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SKZ = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LDA = OP_W'(5);
    localparam logic [OP_W-1:0] OP_STO = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(7);

    typedef enum logic [PHASE_W-1:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    phase_t             state_q;
    phase_t             state_d;
    logic               halted_q;
    logic               halted_d;
    logic [PHASE_W-1:0] phase_inc;
    logic               alu_op;
    logic               is_hlt;
    logic               is_skz;
    logic               is_sto;
    logic               is_jmp;

    assign phase_inc = PHASE_W'(state_q + PHASE_W'(1));
    assign alu_op    = (opcode == OP_ADD) || (opcode == OP_AND) ||
                       (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_hlt    = (opcode == OP_HLT);
    assign is_skz    = (opcode == OP_SKZ);
    assign is_sto    = (opcode == OP_STO);
    assign is_jmp    = (opcode == OP_JMP);
    assign phase     = state_q;

    // State register: phase counter plus sticky halted flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Next state: free-running wrap, frozen at OP_ADDR once a sticky halt lands
    always_comb begin
        state_d  = phase_t'(phase_inc);
        halted_d = halted_q;
        if (halted_q) begin
            state_d = state_q;
        end else if (HALT_STICKY && (state_q == OP_ADDR) && is_hlt) begin
            state_d  = OP_ADDR;
            halted_d = 1'b1;
        end
    end

    // Strobe decode; while halted only halt is driven
    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        inc_pc  = 1'b0;
        load_pc = 1'b0;
        load_ac = 1'b0;
        mem_wr  = 1'b0;
        data_e  = 1'b0;
        halt    = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (state_q)
                INST_ADDR: begin
                end
                INST_FETCH: begin
                    mem_rd = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt;
                end
                OP_FETCH: begin
                    mem_rd = alu_op;
                end
                ALU_OP: begin
                    mem_rd  = alu_op;
                    load_ac = alu_op;
                    inc_pc  = is_skz && zero;
                    load_pc = is_jmp;
                    data_e  = is_sto;
                end
                STORE: begin
                    mem_rd  = alu_op;
                    load_ac = alu_op;
                    inc_pc  = is_jmp;
                    load_pc = is_jmp;
                    data_e  = is_sto;
                    mem_wr  = is_sto;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_seq_m.sv
// Directed bench for ctrl_seq_m: sticky (u_stk) and non-sticky (u_nst) instances share stimulus.
module tb_ctrl_seq_m;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;

    logic mem_rd0, load_ir0, inc_pc0, load_pc0, load_ac0, mem_wr0, data_e0, halt0;
    logic mem_rd1, load_ir1, inc_pc1, load_pc1, load_ac1, mem_wr1, data_e1, halt1;
    logic [2:0] phase0, phase1;
    logic [10:0] obs0, obs1;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, STO = 3'd6, JMP = 3'd7;

    // Byte per phase (phase 0 in LSB): {mem_rd,load_ir,inc_pc,load_pc,load_ac,mem_wr,data_e,halt}
    localparam logic [63:0] T_ADD  = 64'h88_88_80_20_C0_C0_80_00;
    localparam logic [63:0] T_STO  = 64'h06_02_00_20_C0_C0_80_00;
    localparam logic [63:0] T_SKZ1 = 64'h00_20_00_20_C0_C0_80_00;
    localparam logic [63:0] T_SKZ0 = 64'h00_00_00_20_C0_C0_80_00;
    localparam logic [63:0] T_JMP  = 64'h30_10_00_20_C0_C0_80_00;
    localparam logic [63:0] T_HLT  = 64'h00_00_00_21_C0_C0_80_00;

    ctrl_seq_m #(.HALT_STICKY(1'b1)) u_stk (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .mem_rd(mem_rd0), .load_ir(load_ir0), .inc_pc(inc_pc0), .load_pc(load_pc0),
        .load_ac(load_ac0), .mem_wr(mem_wr0), .data_e(data_e0), .halt(halt0), .phase(phase0)
    );

    ctrl_seq_m #(.HALT_STICKY(1'b0)) u_nst (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .mem_rd(mem_rd1), .load_ir(load_ir1), .inc_pc(inc_pc1), .load_pc(load_pc1),
        .load_ac(load_ac1), .mem_wr(mem_wr1), .data_e(data_e1), .halt(halt1), .phase(phase1)
    );

    assign obs0 = {mem_rd0, load_ir0, inc_pc0, load_pc0, load_ac0, mem_wr0, data_e0, halt0, phase0};
    assign obs1 = {mem_rd1, load_ir1, inc_pc1, load_pc1, load_ac1, mem_wr1, data_e1, halt1, phase1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Walks one instruction from phase 0 on both instances, checking every phase
    task automatic run_instr(input string tag, input logic [63:0] tbl);
        for (int p = 0; p < 8; p++) begin
            check($sformatf("%s_stk_p%0d", tag, p), obs0, {tbl[p*8 +: 8], 3'(p)});
            check($sformatf("%s_nst_p%0d", tag, p), obs1, {tbl[p*8 +: 8], 3'(p)});
            tick();
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = ADD;
        zero   = 1'b0;
        #2;
        tick();
        tick();
        check("reset_stk", obs0, 11'h000);
        check("reset_nst", obs1, 11'h000);
        rst = 1'b0;

        run_instr("add", T_ADD);
        run_instr("add_wrap", T_ADD);

        opcode = STO;
        run_instr("sto", T_STO);

        opcode = SKZ;
        zero   = 1'b1;
        run_instr("skz_z1", T_SKZ1);
        zero   = 1'b0;
        run_instr("skz_z0", T_SKZ0);

        opcode = JMP;
        zero   = 1'b1;
        run_instr("jmp", T_JMP);

        // Reset landing in phase 6 of ADD
        opcode = ADD;
        for (int i = 0; i < 6; i++) tick();
        check("midop_p6_stk", obs0, {8'h88, 3'd6});
        rst = 1'b1;
        tick();
        check("midop_rst_stk", obs0, 11'h000);
        check("midop_rst_nst", obs1, 11'h000);
        rst = 1'b0;
        run_instr("after_midop", T_ADD);

        // HLT: sticky freezes at phase 4, non-sticky pulses halt and moves on
        opcode = HLT;
        zero   = 1'b1;
        for (int p = 0; p < 5; p++) begin
            check($sformatf("hlt_stk_p%0d", p), obs0, {T_HLT[p*8 +: 8], 3'(p)});
            check($sformatf("hlt_nst_p%0d", p), obs1, {T_HLT[p*8 +: 8], 3'(p)});
            if (p < 4) tick();
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("halted_stk_%0d", i), obs0, {8'h01, 3'd4});
            if (i < 3) check($sformatf("hlt_nst_p%0d", 5 + i), obs1, {8'h00, 3'(5 + i)});
            if (i >= 2) begin
                opcode = 3'(i);
                zero   = ~zero;
            end
        end
        rst = 1'b1;
        tick();
        check("halt_rst_stk", obs0, 11'h000);
        check("halt_rst_nst", obs1, 11'h000);
        rst    = 1'b0;
        opcode = ADD;
        run_instr("after_halt", T_ADD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
